// File: rtl/serial_paralelo_phy_rx_pkg.sv
// Shared PHY symbol definitions, lock states and defaults for the
// serial/parallel link (TX serializer, RX front end, recirculation).
package serial_paralelo_phy_rx_pkg;

    localparam logic [7:0] COM_CHAR         = 8'hBC;
    localparam logic [7:0] IDL_CHAR         = 8'h7C;
    localparam int         BC_COUNT_DEF     = 4;
    localparam int         LOCK_TIMEOUT_DEF = 64;

    typedef enum logic {
        INIT   = 1'b0,
        ACTIVE = 1'b1
    } rx_state_e;

    typedef enum logic [1:0] {
        SYM_DATA = 2'd0,
        SYM_COM  = 2'd1,
        SYM_IDL  = 2'd2
    } sym_kind_e;

endpackage

// File: rtl/serial_paralelo_phy_rx_byte_decode.sv
// Combinational classification of one received byte as comma,
// idle or payload data.
module serial_paralelo_phy_rx_byte_decode
    import serial_paralelo_phy_rx_pkg::*;
(
    input  logic [7:0] byte_i,
    output sym_kind_e  kind_o
);

    always_comb begin
        kind_o = SYM_DATA;
        unique case (byte_i)
            COM_CHAR: kind_o = SYM_COM;
            IDL_CHAR: kind_o = SYM_IDL;
            default:  kind_o = SYM_DATA;
        endcase
    end

endmodule

// File: rtl/serial_paralelo_phy_rx.sv
// RX PHY front end: COM-based byte alignment and symbol decode.
// Optional lock loss on COM starvation: define SERPAR_RX_LOCK_LOSS_EN.
module serial_paralelo_phy_rx
    import serial_paralelo_phy_rx_pkg::*;
#(
    parameter int BC_COUNT = BC_COUNT_DEF
`ifdef SERPAR_RX_LOCK_LOSS_EN
    ,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
`endif
) (
    input  logic       clk_32f,
    input  logic       default_values,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       idle_out,
    output logic       active,
    output logic       byte_strobe
);

    rx_state_e  state_q, state_d;
    logic [6:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       idle_q, idle_d;
    logic       active_q, active_d;
    logic       strobe_q, strobe_d;
    logic [7:0] next_sr;
    logic       boundary;
    logic       drop;
    sym_kind_e  kind;

`ifdef SERPAR_RX_LOCK_LOSS_EN
    logic [7:0] bytes_q, bytes_d;
`endif

    assign next_sr  = {sr_q, data_in};
    assign boundary = (bit_cnt_q == 3'd7);

    serial_paralelo_phy_rx_byte_decode u_dec (
        .byte_i (next_sr),
        .kind_o (kind)
    );

`ifdef SERPAR_RX_LOCK_LOSS_EN
    assign drop = (bytes_q == 8'(LOCK_TIMEOUT));
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        sr_d      = next_sr[6:0];
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        idle_d    = idle_q;
        active_d  = active_q;
        strobe_d  = 1'b0;
`ifdef SERPAR_RX_LOCK_LOSS_EN
        bytes_d   = bytes_q;
`endif
        unique case (state_q)
            INIT: begin
                valid_d  = 1'b0;
                idle_d   = 1'b0;
                active_d = 1'b0;
                // A first COM may sit at any offset; later ones must be aligned.
                if (kind == SYM_COM && (bc_cnt_q == 4'd0 || boundary)) begin
                    bc_cnt_d  = bc_cnt_q + 4'd1;
                    bit_cnt_d = 3'd0;
                    if (bc_cnt_d == 4'(BC_COUNT)) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
`ifdef SERPAR_RX_LOCK_LOSS_EN
                        bytes_d  = 8'd0;
`endif
                    end
                end else if (boundary && bc_cnt_q != 4'd0) begin
                    bc_cnt_d  = 4'd0;
                    bit_cnt_d = 3'd0;
                end
            end
            ACTIVE: begin
                if (drop) begin
                    state_d  = INIT;
                    active_d = 1'b0;
                    valid_d  = 1'b0;
                    idle_d   = 1'b0;
                    bc_cnt_d = 4'd0;
`ifdef SERPAR_RX_LOCK_LOSS_EN
                    bytes_d  = 8'd0;
`endif
                end else if (boundary) begin
                    strobe_d = 1'b1;
                    unique case (kind)
                        SYM_COM: begin
                            valid_d = 1'b0;
                            idle_d  = 1'b0;
                        end
                        SYM_IDL: begin
                            valid_d = 1'b0;
                            idle_d  = 1'b1;
                        end
                        default: begin
                            data_d  = next_sr;
                            valid_d = 1'b1;
                            idle_d  = 1'b0;
                        end
                    endcase
`ifdef SERPAR_RX_LOCK_LOSS_EN
                    bytes_d = (kind == SYM_COM) ? 8'd0 : bytes_q + 8'd1;
`endif
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (!default_values) begin
            state_q   <= INIT;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            bc_cnt_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            idle_q    <= 1'b0;
            active_q  <= 1'b0;
            strobe_q  <= 1'b0;
`ifdef SERPAR_RX_LOCK_LOSS_EN
            bytes_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            idle_q    <= idle_d;
            active_q  <= active_d;
            strobe_q  <= strobe_d;
`ifdef SERPAR_RX_LOCK_LOSS_EN
            bytes_q   <= bytes_d;
`endif
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign idle_out    = idle_q;
    assign active      = active_q;
    assign byte_strobe = strobe_q;

endmodule
